am_tx_modulator: RTL and testbench
==================================

// Module: am_tx_modulator
// PURPOSE
//  Transmit-side counterpart of the 1-bit AM receive chain. Accepts signed audio samples over a
//  valid/ready handshake, linearly interpolates them up to the system clock rate and forms the AM
//  envelope. It multiplies the envelope by the carrier from the existing nco. A first-order
//  sigma-delta modulator then produces a 1-bit RF output that drives a pin / LC filter directly.
// PARAMETERS
//  SAMPLE_W     16  audio and carrier width (signed two's complement)
//  INTERP_LOG2   8  clocks per audio sample = 2**INTERP_LOG2
//  MOD_SHIFT     1  modulation depth = 2**-MOD_SHIFT (0 = 100%)
// PORTS
//  clk             in   1         system clock (PLL output, ~25 MHz)
//  RSTb            in   1         asynchronous active-low reset
//  enable          in   1         run modulator; low forces IDLE
//  carrier         in   SAMPLE_W  signed carrier (nco cos output), sampled every clk
//  audio_in        in   SAMPLE_W  signed audio sample
//  audio_valid     in   1         audio_in is valid
//  audio_ready     out  1         block accepts audio_in this cycle (valid & ready = transfer)
//  rf_out          out  1         1-bit sigma-delta RF output
//  underrun_count  out  8         saturating count of sample-period wraps with no sample buffered
//  state_o         out  2         current FSM state (debug)
// BEHAVIOUR
//  Reset (RSTb low, async): state=IDLE; rf_out=0, audio_ready=0, underrun_count=0; all regs 0.
//  audio_ready = enable && state!=IDLE && !next_full (combinational). No transfer while it is low.
//  FSM (registered, one step per clk):
//   IDLE : enable=1 -> PRIME. rf_out held 0, SDM accumulator held 0.
//   PRIME: first transfer loads prev=cur=sample, slope=0, cnt=0 -> RUN. Interp value is 0 here,
//          so the output is unmodulated carrier at the MOD_SHIFT depth.
//   RUN  : cnt increments each clk, wraps at 2**INTERP_LOG2-1.
//   Any state: enable=0 -> IDLE next clk; next_full, cnt and SDM acc are cleared.
//  Next-sample buffer (1 entry): a transfer sets next_full. At a RUN wrap:
//   next_full=1 -> prev<=cur, cur<=next, next_full<=0 (a transfer on the same clk is impossible,
//                  because ready is low).
//   next_full=0 -> underrun: prev<=cur (slope 0, output holds flat), underrun_count+=1 saturating
//                  at 255. A transfer in that same clk goes into next, not cur.
//  Interpolator: acc (SAMPLE_W+INTERP_LOG2+1 b, signed).
//   At wrap: acc<=new_prev<<INTERP_LOG2, slope<=new_cur-new_prev (SAMPLE_W+1 b).
//   Otherwise: acc+=slope.
//   interp = acc>>>INTERP_LOG2; this is exactly prev+(cur-prev)*cnt/2**INTERP_LOG2 (floor).
//  Envelope: env = 2**(SAMPLE_W-1) + (interp>>>MOD_SHIFT), unsigned, range [0, 2**SAMPLE_W-1].
//  Mixer: y = (carrier * env) >>> SAMPLE_W, signed SAMPLE_W, registered.
//  SDM: v = sacc + y; rf_out <= (v>=0); sacc <= v - (rf_out ? 2**(SAMPLE_W-1)-1 : -2**(SAMPLE_W-1)).
//   sacc is SAMPLE_W+2 b and cannot overflow for a first-order loop.
//  Latency: carrier -> rf_out 2 clk (mixer reg, SDM reg). Interp update -> rf_out 3 clk.
//  Reset or disable mid-sample discards prev/cur/next. The next enabled transfer re-primes.
// STRUCTURE
//  am_tx_pkg: state encoding (IDLE=0, PRIME=1, RUN=2), SAMPLE_W, and the SDM feedback constants.
//  Sub-module am_sdm1 (first-order 1-bit sigma-delta: clk, RSTb, clr, y, bit).
//  The FSM, buffer, interpolator and mixer live in the top body.
// TESTING
//  1 RSTb low mid-RUN -> same cycle rf_out=0, audio_ready=0, underrun_count=0; state_o=IDLE.
//  2 enable; audio 0x0000 every period; carrier constant +16384 -> y=8192.
//    rf_out ones-density = 0.625 +/- 1/256 over 4096 clk.
//  3 prime 0x0000, then 0x1000, INTERP_LOG2=8 -> interp = 16*cnt across the period.
//    Exactly 0x1000 at the next wrap.
//  4 audio_valid held high -> two transfers back-to-back after PRIME (prime + next).
//    Then exactly one per 256 clk. underrun_count stays 0.
//  5 feed 3 samples then stop -> underrun_count=1 at the 3rd wrap and increments at every later
//    wrap. interp flat at the last value. Resuming valid restores ramps with no glitch.
//  6 enable low mid-period -> IDLE next clk, rf_out=0, audio_ready=0.
//    Re-enable: first sample primes, and the output starts from unmodulated carrier.
//  7 carrier +/-32767 square, audio 0x7FFF, MOD_SHIFT=0 -> no SDM overflow.
//    rf_out density about 1.0 / 0.0 on each half.

Source files
------------

// File: rtl/am_tx_pkg.sv
// Shared definitions for the AM transmit modulator: FSM encoding, default
// sample width and the feedback levels of the 1-bit sigma-delta loop.
package am_tx_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Feedback subtracted after a '1' output: full-scale positive level.
    function automatic int sdm_fb_pos(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Feedback subtracted after a '0' output: full-scale negative level.
    function automatic int sdm_fb_neg(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/am_sdm1.sv
// First-order 1-bit sigma-delta modulator. The decision is registered and the
// feedback applied on each clock is the one selected by the previous decision.
module am_sdm1
    import am_tx_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic                clk,
    input  logic                RSTb,
    input  logic                clr,
    input  logic signed [W-1:0] y,
    output logic                rf_bit
);

    localparam int ACC_W = W + 2;
    localparam int V_W   = W + 3;
    localparam logic signed [V_W-1:0] FB_POS = V_W'(sdm_fb_pos(W));
    localparam logic signed [V_W-1:0] FB_NEG = V_W'(sdm_fb_neg(W));

    logic signed [ACC_W-1:0] sacc;
    logic signed [V_W-1:0]   v;
    logic signed [V_W-1:0]   v_fb;

    // Integrate the input and remove the level of the bit currently on the pin.
    always_comb begin
        v    = V_W'(sacc) + V_W'(y);
        v_fb = v - (rf_bit ? FB_POS : FB_NEG);
    end

    // Decision and accumulator registers; clr parks the loop at zero.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            sacc   <= '0;
            rf_bit <= 1'b0;
        end else if (clr) begin
            sacc   <= '0;
            rf_bit <= 1'b0;
        end else begin
            rf_bit <= ~v[V_W-1];
            sacc   <= v_fb[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/am_tx_modulator.sv
// AM transmit modulator: audio handshake with a one-entry sample buffer,
// linear interpolation to the clock rate, envelope times carrier, and a
// first-order sigma-delta stage producing the 1-bit RF pin drive.
module am_tx_modulator
    import am_tx_pkg::*;
#(
    parameter int SAMPLE_W    = am_tx_pkg::SAMPLE_W,
    parameter int INTERP_LOG2 = 8,
    parameter int MOD_SHIFT   = 1
) (
    input  logic                       clk,
    input  logic                       RSTb,
    input  logic                       enable,
    input  logic signed [SAMPLE_W-1:0] carrier,
    input  logic signed [SAMPLE_W-1:0] audio_in,
    input  logic                       audio_valid,
    output logic                       audio_ready,
    output logic                       rf_out,
    output logic [7:0]                 underrun_count,
    output logic [1:0]                 state_o
);

    localparam int ACC_W  = SAMPLE_W + INTERP_LOG2 + 1;
    localparam int SLP_W  = SAMPLE_W + 1;
    localparam int PROD_W = 2 * SAMPLE_W + 1;

    state_t                     state, state_next;
    logic [INTERP_LOG2-1:0]     cnt;
    logic signed [SAMPLE_W-1:0] prev, cur, nxt;
    logic                       next_full;
    logic signed [SLP_W-1:0]    slope;
    logic signed [ACC_W-1:0]    acc;
    logic signed [SAMPLE_W-1:0] interp;
    logic [SAMPLE_W-1:0]        env;
    logic signed [SAMPLE_W-1:0] y_p1;
    logic                       xfer, wrap, sdm_clr;

    function automatic logic [7:0] sat_inc8(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Offset-binary envelope: midscale plus the depth-scaled audio.
    function automatic logic [SAMPLE_W-1:0] envelope(input logic signed [SAMPLE_W-1:0] iv);
        logic signed [SAMPLE_W-1:0] sh;
        sh = iv >>> MOD_SHIFT;
        return {~sh[SAMPLE_W-1], sh[SAMPLE_W-2:0]};
    endfunction

    // Signed carrier times unsigned envelope, floor-scaled back to SAMPLE_W.
    function automatic logic signed [SAMPLE_W-1:0] mix_scale(
        input logic signed [SAMPLE_W-1:0] car,
        input logic [SAMPLE_W-1:0]        e
    );
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(car) * PROD_W'($signed({1'b0, e}));
        return prod[2*SAMPLE_W-1:SAMPLE_W];
    endfunction

    assign audio_ready = enable && (state != IDLE) && !next_full;
    assign xfer        = audio_valid && audio_ready;
    assign wrap        = (state == RUN) && (cnt == '1);
    assign sdm_clr     = !enable || (state == IDLE);
    assign interp      = acc[SAMPLE_W+INTERP_LOG2-1:INTERP_LOG2];
    assign env         = envelope(interp);
    assign state_o     = state;

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = PRIME;
            PRIME:   if (xfer)   state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) state <= IDLE;
        else       state <= state_next;
    end

    // Sample buffer, period counter and interpolation accumulator.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) begin
            cnt            <= '0;
            prev           <= '0;
            cur            <= '0;
            nxt            <= '0;
            next_full      <= 1'b0;
            slope          <= '0;
            acc            <= '0;
            underrun_count <= '0;
        end else if (!enable) begin
            cnt       <= '0;
            prev      <= '0;
            cur       <= '0;
            nxt       <= '0;
            next_full <= 1'b0;
            slope     <= '0;
            acc       <= '0;
        end else begin
            case (state)
                PRIME: begin
                    if (xfer) begin
                        prev  <= audio_in;
                        cur   <= audio_in;
                        slope <= '0;
                        cnt   <= '0;
                        acc   <= ACC_W'(audio_in) <<< INTERP_LOG2;
                    end
                end
                RUN: begin
                    cnt <= cnt + INTERP_LOG2'(1);
                    if (wrap) begin
                        prev <= cur;
                        acc  <= ACC_W'(cur) <<< INTERP_LOG2;
                        if (next_full) begin
                            cur       <= nxt;
                            slope     <= SLP_W'(nxt) - SLP_W'(cur);
                            next_full <= 1'b0;
                        end else begin
                            slope          <= '0;
                            underrun_count <= sat_inc8(underrun_count);
                        end
                    end else begin
                        acc <= acc + ACC_W'(slope);
                    end
                    if (xfer) begin
                        nxt       <= audio_in;
                        next_full <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: mixer output register.
    always_ff @(posedge clk or negedge RSTb) begin
        if (!RSTb) y_p1 <= '0;
        else       y_p1 <= mix_scale(carrier, env);
    end

    // Stage p2: sigma-delta register drives the pin.
    am_sdm1 #(
        .W (SAMPLE_W)
    ) u_sdm (
        .clk    (clk),
        .RSTb   (RSTb),
        .clr    (sdm_clr),
        .y      (y_p1),
        .rf_bit (rf_out)
    );

endmodule

// File: tb/tb_am_tx_modulator.sv
// Bench for am_tx_modulator: randomized stimulus compared every clock against
// a model built from the interpolation formula and integer arithmetic.
module tb_am_tx_modulator;

    localparam int W   = 16;
    localparam int L   = 8;
    localparam int MS  = 1;
    localparam int PER = 1 << L;

    logic                clk = 1'b0;
    logic                RSTb;
    logic                enable;
    logic signed [W-1:0] carrier;
    logic signed [W-1:0] audio_in;
    logic                audio_valid;
    logic                audio_ready;
    logic                rf_out;
    logic [7:0]          underrun_count;
    logic [1:0]          state_o;

    always #5 clk = ~clk;

    am_tx_modulator #(
        .SAMPLE_W    (W),
        .INTERP_LOG2 (L),
        .MOD_SHIFT   (MS)
    ) dut (
        .clk            (clk),
        .RSTb           (RSTb),
        .enable         (enable),
        .carrier        (carrier),
        .audio_in       (audio_in),
        .audio_valid    (audio_valid),
        .audio_ready    (audio_ready),
        .rf_out         (rf_out),
        .underrun_count (underrun_count),
        .state_o        (state_o)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;

    // Model state: 0 idle, 1 waiting for first sample, 2 running.
    int m_state, m_cnt, m_prev, m_cur, m_under, m_y, m_sacc, m_rf;
    int m_pend[$];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    function automatic int mix_model(input int car);
        longint iv, env;
        iv  = m_prev + fdiv(longint'(m_cur - m_prev) * m_cnt, PER);
        env = (longint'(1) << (W - 1)) + fdiv(iv, longint'(1) << MS);
        return int'(fdiv(longint'(car) * env, longint'(1) << W));
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_prev = 0; m_cur = 0; m_under = 0;
        m_y = 0; m_sacc = 0; m_rf = 0;
        m_pend.delete();
    endtask

    // One clock: drive at negedge, check ready, advance model, check outputs.
    task automatic step(input logic en, input int car, input logic val, input int aud);
        int  exp_ready, new_y, v_m;
        logic xf;
        @(negedge clk);
        enable = en; carrier = W'(car); audio_valid = val; audio_in = W'(aud);
        #1;
        exp_ready = (en && m_state != 0 && m_pend.size() == 0) ? 1 : 0;
        chk("audio_ready", longint'(audio_ready), exp_ready);
        xf = val && (exp_ready == 1);
        if (xf) n_xfer++;
        new_y = mix_model(car);
        v_m   = m_sacc + m_y;
        if (!en || m_state == 0) begin
            m_sacc = 0;
            m_rf   = 0;
        end else begin
            m_sacc = v_m - ((m_rf != 0) ? ((1 << (W - 1)) - 1) : -(1 << (W - 1)));
            m_rf   = (v_m >= 0) ? 1 : 0;
        end
        m_y = new_y;
        if (!en) begin
            m_state = 0; m_cnt = 0; m_prev = 0; m_cur = 0;
            m_pend.delete();
        end else if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 1) begin
            if (xf) begin
                m_prev = aud; m_cur = aud; m_cnt = 0; m_state = 2;
            end
        end else begin
            if (m_cnt == PER - 1) begin
                m_cnt  = 0;
                m_prev = m_cur;
                if (m_pend.size() > 0) m_cur = m_pend.pop_front();
                else if (m_under < 255) m_under++;
            end else begin
                m_cnt++;
            end
            if (xf) m_pend.push_back(aud);
        end
        @(posedge clk);
        #1;
        chk("rf_out", longint'(rf_out), m_rf);
        chk("state_o", longint'(state_o), m_state);
        chk("underrun_count", longint'(underrun_count), m_under);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_out"}, longint'(rf_out), 0);
        chk({tag, "_audio_ready"}, longint'(audio_ready), 0);
        chk({tag, "_underrun"}, longint'(underrun_count), 0);
        chk({tag, "_state"}, longint'(state_o), 0);
    endtask

    // Assert reset between edges, check immediately, release away from edges.
    task automatic async_reset();
        @(negedge clk);
        #2 RSTb = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #2 RSTb = 1'b1;
    endtask

    initial begin
        int ones, n_hi, n_lo, ones_hi, ones_lo, car, car_d1, car_d2, drop, x0;
        longint env7, yh, yl, exp_hi, exp_lo;

        RSTb = 1'b0; enable = 1'b0; audio_valid = 1'b0;
        carrier = '0; audio_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("init_rst");
        #1 RSTb = 1'b1;

        // Silent audio, constant carrier: y = 8192, density (8192+32768)/65535.
        repeat (300) step(1'b1, 16384, 1'b1, 0);
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            step(1'b1, 16384, 1'b1, 0);
            if (rf_out) ones++;
        end
        chk("ones_4096_near_2560", (ones >= 2544 && ones <= 2576) ? 2560 : ones, 2560);

        // Prime 0 then 0x1000 ramp, valid held high, random carrier.
        repeat (2) step(1'b0, rnd_s(), 1'b0, 0);
        n_xfer = 0;
        for (int i = 0; i < 6 * PER; i++)
            step(1'b1, rnd_s(), 1'b1, (n_xfer == 0) ? 0 : (n_xfer == 1) ? 4096 : rnd_s());
        x0 = n_xfer;
        repeat (4 * PER) step(1'b1, rnd_s(), 1'b1, rnd_s());
        chk("xfers_per_4_periods", n_xfer - x0, 4);

        // Reset while running.
        async_reset();

        // Three samples then starve: underruns from the third wrap onwards.
        step(1'b0, rnd_s(), 1'b0, 0);
        n_xfer = 0;
        for (int i = 0; i < 8 * PER; i++)
            step(1'b1, rnd_s(), (n_xfer < 3), rnd_s());
        chk("underrun_after_stop", longint'(underrun_count), 5);
        repeat (3 * PER) step(1'b1, rnd_s(), 1'b1, rnd_s());
        chk("underrun_after_resume", longint'(underrun_count), 5);

        // Disable mid-period, then re-prime.
        repeat (100) step(1'b1, rnd_s(), 1'b1, rnd_s());
        step(1'b0, rnd_s(), 1'b1, rnd_s());
        chk("idle_after_disable", longint'(state_o), 0);
        chk("rf_after_disable", longint'(rf_out), 0);
        step(1'b0, rnd_s(), 1'b1, rnd_s());
        repeat (600) step(1'b1, rnd_s(), 1'b1, rnd_s());

        // Full-scale square carrier with full-scale audio.
        step(1'b0, 0, 1'b0, 0);
        n_hi = 0; n_lo = 0; ones_hi = 0; ones_lo = 0; car_d1 = 0; car_d2 = 0;
        for (int i = 0; i < 9 * PER; i++) begin
            car = (((i / 64) % 2) == 0) ? 32767 : -32767;
            step(1'b1, car, 1'b1, 32767);
            if (i >= PER + 2) begin
                if (car_d2 > 0) begin n_hi++; if (rf_out) ones_hi++; end
                else begin n_lo++; if (rf_out) ones_lo++; end
            end
            car_d2 = car_d1;
            car_d1 = car;
        end
        env7   = (longint'(1) << (W - 1)) + fdiv(32767, longint'(1) << MS);
        yh     = fdiv(longint'(32767) * env7, longint'(1) << W);
        yl     = fdiv(longint'(-32767) * env7, longint'(1) << W);
        exp_hi = (longint'(n_hi) * (yh + 32768)) / 65535;
        exp_lo = (longint'(n_lo) * (yl + 32768)) / 65535;
        chk("square_hi_density", (ones_hi >= exp_hi - n_hi / 16 && ones_hi <= exp_hi + n_hi / 16) ? exp_hi : ones_hi, exp_hi);
        chk("square_lo_density", (ones_lo >= exp_lo - n_lo / 16 && ones_lo <= exp_lo + n_lo / 16) ? exp_lo : ones_lo, exp_lo);

        // Random traffic: sparse valid, occasional enable drops.
        drop = 0;
        for (int i = 0; i < 4000; i++) begin
            if (drop == 0 && $urandom_range(0, 1499) == 0) drop = int'($urandom_range(1, 3));
            if (drop > 0) begin
                step(1'b0, rnd_s(), ($urandom_range(0, 1) == 1), rnd_s());
                drop--;
            end else begin
                step(1'b1, rnd_s(), ($urandom_range(0, 99) == 0), rnd_s());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
